snes_poll_scheduler: RTL and testbench
======================================

SNES_POLL_SCHEDULER -- requirements
Module: snes_poll_scheduler

Interface
REQ-001 Parameter LATCH_CYC, default 600: LATCH high time in CLOCK cycles (12 us at 50 MHz).
REQ-002 Parameter HALF_CYC, default 300: PULSE half-period in cycles (6 us).
REQ-003 Parameter POLL_CYC, default 833333: poll period in cycles (60 Hz).
REQ-004 CLOCK  in  1: single clock; every flop is clocked on its rising edge.
REQ-005 RESET  in  1: asynchronous, active-high reset.
REQ-006 ENABLE  in  1: when 1, a poll starts on each poll tick.
REQ-007 DATA1  in  1: serial data from player-1 pad; active-low (0 = pressed).
REQ-008 DATA2  in  1: serial data from player-2 pad; active-low.
REQ-009 LATCH  out  1: shared latch strobe to both pads.
REQ-010 PULSE  out  1: shared shift clock to both pads; idles high.
REQ-011 BUTTONS1  out  12: player-1 buttons, active-high, bit0..11 = B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R.
REQ-012 BUTTONS2  out  12: player-2 buttons, same encoding as BUTTONS1.
REQ-013 VALID  out  1: one-cycle pulse when BUTTONS1/2 update.
REQ-014 BUSY  out  1: high from LATCH rise through the VALID cycle.

Function
REQ-015 A free-running poll counter SHALL count 0..POLL_CYC-1 and wrap; the wrap cycle is the poll tick.
REQ-016 On a poll tick with ENABLE=1 in IDLE, the FSM SHALL enter LATCH on the next cycle; a tick with ENABLE=0 SHALL be ignored.
REQ-017 The FSM states SHALL be IDLE, LATCH, HIGH, LOW, DONE.
REQ-018 In LATCH, LATCH=1 and PULSE=1 for exactly LATCH_CYC cycles, then the FSM enters HIGH with bit index 0.
REQ-019 In HIGH, LATCH=0 and PULSE=1 for HALF_CYC cycles; on the last cycle, both synchronized DATA lines are sampled into bit[index].
REQ-020 In LOW, PULSE=0 for HALF_CYC cycles; at exit, index increments; if index was 15, go to DONE, else go to HIGH.
REQ-021 All 16 bits SHALL be clocked; bits 12..15 are sampled and discarded.
REQ-022 In DONE (one cycle), BUTTONS1/2 SHALL load the inverted sampled bits 11..0 and VALID=1; the next state is IDLE.
REQ-023 BUTTONS1/2 SHALL hold between VALID pulses; partial samples are never visible on these outputs.
REQ-024 DATA1/DATA2 SHALL pass through a 2-flop synchronizer before sampling.
REQ-025 ENABLE falling mid-transaction SHALL NOT abort; the poll completes and VALID fires.
REQ-026 A poll tick while BUSY SHALL be ignored; POLL_CYC > LATCH_CYC + 32*HALF_CYC + 2 is a legal-parameter requirement, checked by an elaboration assertion.
REQ-027 Transaction length, LATCH rise to VALID, SHALL be LATCH_CYC + 32*HALF_CYC + 1 cycles.

Reset
REQ-028 While RESET=1, the following SHALL hold: FSM=IDLE, poll counter=0, LATCH=0, PULSE=1, BUTTONS1/2=0, VALID=0, BUSY=0, synchronizers=1.
REQ-029 RESET asserted mid-transaction SHALL take effect immediately (asynchronous); no VALID follows, and the previous BUTTONS values are cleared.
REQ-030 After RESET release, the first poll tick SHALL occur POLL_CYC-1 cycles later.

Structure
REQ-031 Package snes_pkg SHALL hold:
- default timing constants;
- the FSM state enum;
- named button bit indices (BTN_B..BTN_R).
REQ-032 One sub-module, sync_2ff, SHALL be instantiated once per DATA input; the rest is flat.

Verification (sim params LATCH_CYC=6, HALF_CYC=3, POLL_CYC=200)
REQ-033 Both pads model all-released (DATA=1 throughout) -> VALID pulses once, BUTTONS1=BUTTONS2=12'h000, 103 cycles after LATCH rise.
REQ-034 Pad1 drives serial word 16'hFEFE (bit0 first, active-low), pad2 drives 16'hFFF0 -> BUTTONS1=12'h101, BUTTONS2=12'h00F.
REQ-035 ENABLE=0 across a tick -> no LATCH and no VALID; then ENABLE=1 -> poll on the next tick, with exactly 16 PULSE falling edges.
REQ-036 ENABLE dropped at the 40th cycle of a poll -> the poll completes, VALID=1, then no further LATCH.
REQ-037 RESET pulsed during HIGH of bit 5 -> LATCH=0, PULSE=1, BUTTONS=0 at once; no VALID; the next poll starts 199 cycles after release.
REQ-038 Timing check -> LATCH width = 6 cycles, each PULSE low = 3 cycles, each PULSE high = 3 cycles, and consecutive LATCH rises are 200 cycles apart.

Source files
------------

// File: rtl/snes_pkg.sv
// ---------------------------------------------------------------------------
// snes_pkg
// Shared definitions for the SNES controller poll scheduler:
//   - default timing constants for a 50 MHz clock
//   - FSM state encoding
//   - named bit positions within the 12-bit BUTTONS words
// ---------------------------------------------------------------------------
package snes_pkg;

    // Default timing, in clock cycles at 50 MHz
    localparam int LATCH_CYC_DEF = 600;     // 12 us latch strobe
    localparam int HALF_CYC_DEF  = 300;     // 6 us shift-clock half period
    localparam int POLL_CYC_DEF  = 833333;  // 60 Hz poll period

    // The pad always shifts out 16 bits; only the first 12 are buttons.
    localparam int NUM_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit positions inside BUTTONS1/BUTTONS2 (serial order from the pad)
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int NUM_BTN = BTN_R + 1;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for one asynchronous pad data line. Both flops
// reset to 1, the idle (released) level of an SNES data line.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (two cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/snes_poll_scheduler.sv
// ---------------------------------------------------------------------------
// snes_poll_scheduler
// Periodically polls two SNES controllers sharing LATCH/PULSE and publishes
// their 12 button bits as active-high words.
//
// Ports:
//   CLOCK     - single clock, rising edge
//   RESET     - asynchronous active-high reset
//   ENABLE    - a poll starts on a poll tick only while ENABLE=1
//   DATA1/2   - serial pad data, active-low, asynchronous
//   LATCH     - shared latch strobe
//   PULSE     - shared shift clock, idles high
//   BUTTONS1/2- button words, bit order B,Y,Sel,Start,U,D,L,R,A,X,L,R
//   VALID     - one-cycle strobe in the cycle BUTTONS1/2 take new values
//   BUSY      - high from LATCH rise through the VALID cycle
//
// Handshake: VALID is a plain one-cycle strobe with no ready/back-pressure;
// BUTTONS1/2 are stable from the VALID cycle until the next VALID.
//
// Timing: LATCH rises in the cycle after the poll tick. A poll is
// LATCH_CYC cycles of LATCH, then 16 x (HALF_CYC high + HALF_CYC low) of
// PULSE, then one DONE cycle; VALID is registered from DONE, so LATCH rise
// to VALID is LATCH_CYC + 32*HALF_CYC + 1 cycles.
// ---------------------------------------------------------------------------
module snes_poll_scheduler
    import snes_pkg::*;
#(
    parameter int LATCH_CYC = LATCH_CYC_DEF,
    parameter int HALF_CYC  = HALF_CYC_DEF,
    parameter int POLL_CYC  = POLL_CYC_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        DATA1,
    input  logic        DATA2,
    output logic        LATCH,
    output logic        PULSE,
    output logic [11:0] BUTTONS1,
    output logic [11:0] BUTTONS2,
    output logic        VALID,
    output logic        BUSY
);

    localparam int CNT_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POLL_W  = $clog2(POLL_CYC);

    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);
    localparam logic [3:0]        IDX_LAST   = 4'(NUM_BITS - 1);

    // A poll must finish (including the VALID cycle) before the next tick.
    generate
        if (POLL_CYC <= LATCH_CYC + 32 * HALF_CYC + 2) begin : g_bad_params
            $error("snes_poll_scheduler: POLL_CYC too short for one poll");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [POLL_W-1:0]   poll_q;
    logic                poll_tick;
    logic                sample_en;
    logic                data1_s, data2_s;
    logic [NUM_BTN-1:0]  samp1_q, samp2_q;
    logic [NUM_BTN-1:0]  btn1_q, btn2_q;
    logic                valid_q;

    sync_2ff u_sync1 (.clk_i(CLOCK), .rst_i(RESET), .d_i(DATA1), .q_o(data1_s));
    sync_2ff u_sync2 (.clk_i(CLOCK), .rst_i(RESET), .d_i(DATA2), .q_o(data2_s));

    // Free-running poll counter; the wrap cycle is the tick.
    assign poll_tick = (poll_q == POLL_LAST);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)          poll_q <= '0;
        else if (poll_tick) poll_q <= '0;
        else                poll_q <= poll_q + 1'b1;
    end

    // FSM state register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // valid_q guard keeps the VALID cycle inside the busy window
                if (poll_tick && ENABLE && !valid_q) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        LATCH = (state_q == ST_LATCH);
        PULSE = (state_q != ST_LOW);
        BUSY  = (state_q != ST_IDLE) || valid_q;
    end

    // Sample on the last HIGH cycle; bits 12..15 have no slot and drop out.
    assign sample_en = (state_q == ST_HIGH) && (cnt_q == HALF_LAST);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            samp1_q <= '0;
            samp2_q <= '0;
        end else if (sample_en) begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (idx_q == 4'(b)) begin
                    samp1_q[b] <= data1_s;
                    samp2_q[b] <= data2_s;
                end
            end
        end
    end

    // Publish whole words only, so a partial shift is never visible.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            btn1_q  <= '0;
            btn2_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                btn1_q <= ~samp1_q;
                btn2_q <= ~samp2_q;
            end
        end
    end

    assign BUTTONS1 = btn1_q;
    assign BUTTONS2 = btn2_q;
    assign VALID    = valid_q;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_snes_poll_scheduler
// Directed bench with a behavioural model of two SNES pads (latch loads the
// 16-bit word, each PULSE rising edge presents the next bit, bit0 first).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snes_poll_scheduler;

    localparam int LATCH_CYC = 6;
    localparam int HALF_CYC  = 3;
    localparam int POLL_CYC  = 200;
    localparam int TXN_CYC   = LATCH_CYC + 32 * HALF_CYC + 1;  // 103

    logic        clk = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        DATA1;
    logic        DATA2;
    logic        LATCH;
    logic        PULSE;
    logic [11:0] BUTTONS1;
    logic [11:0] BUTTONS2;
    logic        VALID;
    logic        BUSY;

    snes_poll_scheduler #(
        .LATCH_CYC(LATCH_CYC),
        .HALF_CYC (HALF_CYC),
        .POLL_CYC (POLL_CYC)
    ) dut (
        .CLOCK   (clk),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .LATCH   (LATCH),
        .PULSE   (PULSE),
        .BUTTONS1(BUTTONS1),
        .BUTTONS2(BUTTONS2),
        .VALID   (VALID),
        .BUSY    (BUSY)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pad model ----------------
    logic [15:0] w1 = 16'hFFFF;
    logic [15:0] w2 = 16'hFFFF;
    int          pad_k = 0;
    logic        pad_prev = 1'b1;

    initial begin
        DATA1 = 1'b1;
        DATA2 = 1'b1;
    end

    always @(negedge clk) begin
        if (LATCH)                          pad_k = 0;
        else if (PULSE && !pad_prev)        pad_k = pad_k + 1;
        pad_prev = PULSE;
        DATA1 = (pad_k < 16) ? w1[pad_k] : 1'b1;
        DATA2 = (pad_k < 16) ? w2[pad_k] : 1'b1;
    end

    // ---------------- waveform monitor ----------------
    int   valid_cnt = 0;
    int   fall_cnt  = 0;
    int   lo_run = 0, hi_run = 0, latch_run = 0;
    int   lo_min = 9999, lo_max = 0;
    int   hi_min = 9999, hi_max = 0;
    int   lw_min = 9999, lw_max = 0;
    logic mon_pulse = 1'b1;

    always @(negedge clk) begin
        if (VALID) valid_cnt = valid_cnt + 1;
        if (!PULSE && mon_pulse) fall_cnt = fall_cnt + 1;
        // PULSE low widths
        if (!PULSE) lo_run = lo_run + 1;
        else if (lo_run > 0) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
            lo_run = 0;
        end
        // PULSE high widths between LATCH fall / previous low and a fall
        if (LATCH) hi_run = 0;
        else if (PULSE) hi_run = hi_run + 1;
        else if (hi_run > 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        // LATCH widths
        if (LATCH) latch_run = latch_run + 1;
        else if (latch_run > 0) begin
            if (latch_run < lw_min) lw_min = latch_run;
            if (latch_run > lw_max) lw_max = latch_run;
            latch_run = 0;
        end
        mon_pulse = PULSE;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns the cycle of the first negedge at which LATCH is seen high.
    task automatic wait_latch(input string tag, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc && at < 0; i++) begin
            @(negedge clk);
            if (LATCH) at = cyc;
        end
        check_eq({tag, "_latch_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc && at < 0; i++) begin
            @(negedge clk);
            if (VALID) at = cyc;
        end
        check_eq({tag, "_valid_seen"}, 32'(at >= 0), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rel, rise, prev_rise, vat, f0, v0, nl, nv;

        RESET  = 1'b1;
        ENABLE = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check_eq("rst_latch", 32'(LATCH), 32'd0);
        check_eq("rst_pulse", 32'(PULSE), 32'd1);
        check_eq("rst_valid", 32'(VALID), 32'd0);
        check_eq("rst_busy",  32'(BUSY),  32'd0);
        check_eq("rst_btn1",  32'(BUTTONS1), 32'h000);
        check_eq("rst_btn2",  32'(BUTTONS2), 32'h000);

        // ENABLE=0 across the first tick: no LATCH, no VALID
        RESET = 1'b0;
        rel = cyc;
        nl = 0;
        nv = 0;
        repeat (250) begin
            @(negedge clk);
            if (LATCH) nl++;
            if (VALID) nv++;
        end
        check_eq("dis_latch_cnt", 32'(nl), 32'd0);
        check_eq("dis_valid_cnt", 32'(nv), 32'd0);

        // ENABLE=1: poll on the second tick (tick at POLL_CYC-1, LATCH next)
        ENABLE = 1'b1;
        f0 = fall_cnt;
        v0 = valid_cnt;
        wait_latch("en", 200, rise);
        check_eq("en_rise_time", 32'(rise - rel), 32'(2 * POLL_CYC));
        wait_valid("rel", 150, vat);
        check_eq("rel_txn_len", 32'(vat - rise), 32'(TXN_CYC));
        check_eq("rel_busy_at_valid", 32'(BUSY), 32'd1);
        check_eq("rel_btn1", 32'(BUTTONS1), 32'h000);
        check_eq("rel_btn2", 32'(BUTTONS2), 32'h000);
        check_eq("rel_falls", 32'(fall_cnt - f0), 32'd16);
        @(negedge clk);
        check_eq("rel_busy_after", 32'(BUSY), 32'd0);
        check_eq("rel_valid_once", 32'(valid_cnt - v0), 32'd1);

        // Mixed pattern
        w1 = 16'hFEFE;
        w2 = 16'hFFF0;
        prev_rise = rise;
        wait_latch("pat", 200, rise);
        check_eq("pat_period", 32'(rise - prev_rise), 32'(POLL_CYC));
        wait_valid("pat", 150, vat);
        check_eq("pat_btn1", 32'(BUTTONS1), 32'h101);
        check_eq("pat_btn2", 32'(BUTTONS2), 32'h00F);

        // Hold between VALIDs; bit 15 pressed is discarded
        w1 = 16'hFFFE;
        w2 = 16'h7FFF;
        wait_latch("hold", 200, rise);
        repeat (50) @(negedge clk);
        check_eq("hold_btn1", 32'(BUTTONS1), 32'h101);
        check_eq("hold_btn2", 32'(BUTTONS2), 32'h00F);
        wait_valid("hold", 150, vat);
        check_eq("new_btn1", 32'(BUTTONS1), 32'h001);
        check_eq("new_btn2", 32'(BUTTONS2), 32'h000);

        // ENABLE dropped at the 40th cycle of a poll: poll completes
        w1 = 16'hFEFE;
        w2 = 16'hFFF0;
        wait_latch("drop", 200, rise);
        repeat (39) @(negedge clk);
        ENABLE = 1'b0;
        wait_valid("drop", 150, vat);
        check_eq("drop_txn_len", 32'(vat - rise), 32'(TXN_CYC));
        check_eq("drop_btn1", 32'(BUTTONS1), 32'h101);
        check_eq("drop_btn2", 32'(BUTTONS2), 32'h00F);
        nl = 0;
        repeat (250) begin
            @(negedge clk);
            if (LATCH) nl++;
        end
        check_eq("drop_no_latch", 32'(nl), 32'd0);

        // Reset during HIGH of bit 5
        ENABLE = 1'b1;
        wait_latch("rst", 250, rise);
        repeat (LATCH_CYC + 5 * 2 * HALF_CYC + 1) @(negedge clk);
        check_eq("mid_in_high", 32'(PULSE), 32'd1);
        check_eq("mid_busy", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_latch", 32'(LATCH), 32'd0);
        check_eq("mid_rst_pulse", 32'(PULSE), 32'd1);
        check_eq("mid_rst_btn1", 32'(BUTTONS1), 32'h000);
        check_eq("mid_rst_btn2", 32'(BUTTONS2), 32'h000);
        check_eq("mid_rst_busy", 32'(BUSY), 32'd0);
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        rel = cyc;
        v0 = valid_cnt;
        wait_latch("post_rst", 250, rise);
        check_eq("post_rst_start", 32'(rise - rel), 32'(POLL_CYC));
        check_eq("post_rst_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Waveform timing accumulated over all complete polls
        check_eq("latch_w_min", 32'(lw_min), 32'(LATCH_CYC));
        check_eq("latch_w_max", 32'(lw_max), 32'(LATCH_CYC));
        check_eq("pulse_lo_min", 32'(lo_min), 32'(HALF_CYC));
        check_eq("pulse_lo_max", 32'(lo_max), 32'(HALF_CYC));
        check_eq("pulse_hi_min", 32'(hi_min), 32'(HALF_CYC));
        check_eq("pulse_hi_max", 32'(hi_max), 32'(HALF_CYC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
